// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer port arbiter.
// The frame RAM is addressed as {y[7:0], x[7:0]} over a 256x240 NES image.
package fb_pkg;

    localparam int DATA_W = 9;
    localparam int ADDR_W = 16;
    localparam int NES_W  = 256;
    localparam int NES_H  = 240;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        TURN  = 2'd2,
        WRITE = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rgb;
    } fifo_entry_t;

    // Lines at or beyond the visible height have no storage in the frame RAM.
    function automatic logic y_in_range(input logic [7:0] y);
        return ({8'd0, y} < 16'(NES_H));
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO with valid/ready push and unconditional pop request.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fb_wr_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic                     pix_clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic             push_fire_s;
    logic             pop_fire_s;

    assign full        = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty       = (wr_ptr_r == rd_ptr_r);
    assign level       = wr_ptr_r - rd_ptr_r;
    assign push_ready  = !full;
    assign push_fire_s = push_valid && !full;
    assign pop_fire_s  = pop && !empty;
    assign pop_data    = mem_r[rd_ptr_r[PW-1:0]];

    // Pointer update; reset discards everything queued.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (pop_fire_s) begin
                rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage needs no reset: the pointers define what is valid.
    always_ff @(posedge pix_clk) begin
        if (push_fire_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates the single-port frame RAM between VGA scan-out reads (absolute
// priority) and buffered PPU pixel writes drained whenever the VGA is idle.
module fb_port_arbiter #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        pix_clk,
    input  logic                        reset,
    input  logic                        vga_rd_en,
    input  logic [7:0]                  vga_x,
    input  logic [7:0]                  vga_y,
    output logic [fb_pkg::DATA_W-1:0]   vga_rdata,
    output logic                        vga_rvalid,
    input  logic                        ppu_wr_valid,
    output logic                        ppu_wr_ready,
    input  logic [7:0]                  ppu_x,
    input  logic [7:0]                  ppu_y,
    input  logic [fb_pkg::DATA_W-1:0]   ppu_rgb,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [fb_pkg::ADDR_W-1:0]   mem_addr,
    output logic [fb_pkg::DATA_W-1:0]   mem_wdata,
    input  logic [fb_pkg::DATA_W-1:0]   mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_count
);

    import fb_pkg::*;

    arb_state_e        state_r;
    arb_state_e        state_next_s;
    fifo_entry_t       push_entry_s;
    fifo_entry_t       head_s;
    logic              in_range_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_ready_s;
    logic              pop_s;
    logic              drop_inc_s;
    logic [15:0]       drop_count_r;
    logic [DATA_W-1:0] rdata_hold_r;

    assign in_range_s   = y_in_range(ppu_y);
    assign push_entry_s = '{addr: {ppu_y, ppu_x}, rgb: ppu_rgb};
    assign ppu_wr_ready = fifo_ready_s;
    assign drop_inc_s   = ppu_wr_valid && !fifo_full_s && !in_range_s;
    assign pop_s        = (state_next_s == WRITE);

    fb_wr_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .pix_clk    (pix_clk),
        .reset      (reset),
        .push_valid (ppu_wr_valid && in_range_s),
        .push_ready (fifo_ready_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .pop_data   (head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .level      (fifo_level)
    );

    // Next-state decision; a read always wins and leaving READ costs one TURN.
    always_comb begin
        state_next_s = IDLE;
        if (reset) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                READ:               state_next_s = vga_rd_en ? READ : TURN;
                IDLE, TURN, WRITE:  state_next_s = vga_rd_en ? READ :
                                                   (!fifo_empty_s ? WRITE : IDLE);
                default:            state_next_s = IDLE;
            endcase
        end
    end

    // RAM port decode from the next state so reads pre-empt writes with no delay.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_next_s)
            READ: begin
                mem_en   = 1'b1;
                mem_addr = {vga_y, vga_x};
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_s.addr;
                mem_wdata = head_s.rgb;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Being in READ means the RAM was read last cycle, so its data is fresh now.
    assign vga_rvalid = (state_r == READ);
    assign vga_rdata  = vga_rvalid ? mem_rdata : rdata_hold_r;

    // Keep the last returned pixel stable between read returns.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            rdata_hold_r <= '0;
        end else if (vga_rvalid) begin
            rdata_hold_r <= mem_rdata;
        end
    end

    // Saturating count of off-screen writes swallowed by the handshake.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            drop_count_r <= 16'd0;
        end else if (drop_inc_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
        end
    end

    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomised and directed bench for fb_port_arbiter against a queue-based
// model of the arbitration rules and a behavioural synchronous RAM.
module tb_fb_port_arbiter;

    logic        pix_clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_rd_en = 1'b0;
    logic [7:0]  vga_x = 8'd0, vga_y = 8'd0;
    logic [8:0]  vga_rdata;
    logic        vga_rvalid;
    logic        ppu_wr_valid = 1'b0;
    logic        ppu_wr_ready;
    logic [7:0]  ppu_x = 8'd0, ppu_y = 8'd0;
    logic [8:0]  ppu_rgb = 9'd0;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [8:0]  mem_wdata;
    logic [8:0]  mem_rdata;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model state
    logic [24:0] q[$];
    logic [8:0]  ref_mem[int];
    logic        prev_read = 1'b0;
    logic        exp_rvalid = 1'b0;
    logic [8:0]  exp_rdata = 9'd0;
    logic [15:0] drop_m = 16'd0;

    // Behavioural RAM; unwritten locations read back as addr[8:0]
    logic [8:0]  ram [0:65535];
    bit          ram_v [0:65535];
    logic [8:0]  ram_q;
    assign mem_rdata = ram_q;

    always #40 pix_clk = ~pix_clk;

    always @(posedge pix_clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]   <= mem_wdata;
                ram_v[mem_addr] <= 1'b1;
            end else begin
                ram_q <= ram_v[mem_addr] ? ram[mem_addr] : mem_addr[8:0];
            end
        end
    end

    fb_port_arbiter #(.FIFO_DEPTH(8)) dut (
        .pix_clk      (pix_clk),
        .reset        (reset),
        .vga_rd_en    (vga_rd_en),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_rdata    (vga_rdata),
        .vga_rvalid   (vga_rvalid),
        .ppu_wr_valid (ppu_wr_valid),
        .ppu_wr_ready (ppu_wr_ready),
        .ppu_x        (ppu_x),
        .ppu_y        (ppu_y),
        .ppu_rgb      (ppu_rgb),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [8:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return a[8:0];
    endfunction

    // One clock: check outputs for the current inputs, then advance the model
    task automatic tick();
        int          op;     // 0 none, 1 read, 2 write
        logic        ready_e;
        logic [24:0] head;
        logic [15:0] raddr;
        #1;
        ready_e = (q.size() < 8);
        head    = (q.size() > 0) ? q[0] : 25'd0;
        raddr   = {vga_y, vga_x};
        op      = 0;
        if (!reset) begin
            if (vga_rd_en)           op = 1;
            else if (prev_read)      op = 0;
            else if (q.size() > 0)   op = 2;
            check("mem_en", mem_en, (op != 0));
            check("mem_we", mem_we, (op == 2));
            if (op == 1) check("rd_addr", mem_addr, raddr);
            if (op == 2) begin
                check("wr_addr", mem_addr, head[24:9]);
                check("wr_data", mem_wdata, head[8:0]);
            end
        end
        check("wr_ready", ppu_wr_ready, ready_e);
        check("fifo_level", fifo_level, q.size());
        check("rvalid", vga_rvalid, exp_rvalid);
        check("rdata", vga_rdata, exp_rdata);
        check("drop_count", drop_count, drop_m);
        @(posedge pix_clk);
        if (reset) begin
            q.delete();
            prev_read  = 1'b0;
            exp_rvalid = 1'b0;
            exp_rdata  = 9'd0;
            drop_m     = 16'd0;
        end else begin
            exp_rvalid = (op == 1);
            if (op == 1) exp_rdata = ref_read(raddr);
            if (op == 2) begin
                ref_mem[int'(head[24:9])] = head[8:0];
                void'(q.pop_front());
            end
            if (ppu_wr_valid && ready_e) begin
                if (ppu_y < 8'd240) q.push_back({ppu_y, ppu_x, ppu_rgb});
                else if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
            end
            prev_read = (op == 1);
        end
        @(negedge pix_clk);
    endtask

    initial begin
        logic [8:0] rgb3 [3];

        repeat (2) @(posedge pix_clk);
        @(negedge pix_clk);
        reset = 1'b0;

        // Idle after reset
        repeat (10) tick();

        // Read a full line
        vga_rd_en = 1'b1;
        vga_y     = 8'd5;
        for (int x = 0; x < 256; x++) begin
            vga_x = 8'(x);
            tick();
        end
        vga_rd_en = 1'b0;
        tick();

        // Fill the FIFO while reads hold the bus, then drain after TURN
        vga_rd_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            vga_x        = 8'($urandom_range(0, 255));
            ppu_wr_valid = 1'b1;
            ppu_x        = 8'(i * 3);
            ppu_y        = 8'($urandom_range(0, 239));
            ppu_rgb      = 9'($urandom_range(0, 511));
            if (i == 8) begin
                #1;
                check("full_level", fifo_level, 32'd8);
                check("full_ready", ppu_wr_ready, 32'd0);
            end
            tick();
        end
        ppu_wr_valid = 1'b0;
        vga_rd_en    = 1'b0;
        repeat (12) tick();
        check("drained", fifo_level, 32'd0);

        // Three writes with a read landing on the second write slot
        vga_rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rgb3[i]      = 9'($urandom_range(0, 511));
            ppu_wr_valid = 1'b1;
            ppu_x        = 8'(10 + i);
            ppu_y        = 8'd100;
            ppu_rgb      = rgb3[i];
            tick();
        end
        ppu_wr_valid = 1'b0;
        vga_rd_en    = 1'b0;
        tick();
        tick();
        vga_rd_en = 1'b1;
        vga_x     = 8'd77;
        tick();
        vga_rd_en = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) check("ram_pre", ram[{8'd100, 8'(10 + i)}], rgb3[i]);
        check("pre_level", fifo_level, 32'd0);

        // Off-screen writes are dropped and counted
        ppu_wr_valid = 1'b1;
        ppu_y        = 8'd240;
        tick();
        ppu_y = 8'd255;
        tick();
        ppu_wr_valid = 1'b0;
        tick();
        check("drop2", drop_count, 32'd2);
        force dut.drop_count_r = 16'hFFFF;
        #1;
        release dut.drop_count_r;
        drop_m       = 16'hFFFF;
        ppu_wr_valid = 1'b1;
        ppu_y        = 8'd250;
        tick();
        ppu_wr_valid = 1'b0;
        tick();
        check("drop_sat", drop_count, 32'hFFFF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            vga_rd_en    = ($urandom_range(0, 2) == 0);
            vga_x        = 8'($urandom_range(0, 255));
            vga_y        = 8'($urandom_range(0, 239));
            ppu_wr_valid = ($urandom_range(0, 1) == 1);
            ppu_x        = 8'($urandom_range(0, 255));
            ppu_y        = 8'($urandom_range(0, 255));
            ppu_rgb      = 9'($urandom_range(0, 511));
            tick();
        end
        ppu_wr_valid = 1'b0;
        vga_rd_en    = 1'b0;
        repeat (12) tick();

        // Reset with queued writes and a read in flight
        vga_rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ppu_wr_valid = 1'b1;
            ppu_x        = 8'(i);
            ppu_y        = 8'd200;
            ppu_rgb      = 9'($urandom_range(0, 511));
            tick();
        end
        ppu_wr_valid = 1'b0;
        check("pre_rst_level", fifo_level, 32'd5);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        vga_rd_en = 1'b0;
        #1;
        check("rst_level", fifo_level, 32'd0);
        check("rst_rvalid", vga_rvalid, 32'd0);
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port 9-bit frame RAM (256x240 NES image, address {y[7:0],x[7:0]}) between the VGA scan-out path and the PPU pixel writer, all in the pix_clk domain.
- VGA reads have absolute priority while the VGA driver's read strobe is high.
- PPU writes are buffered in a small FIFO and drained when the VGA driver is not reading: in the side borders, the blanking intervals and the odd (repeated) lines.

Parameters:
- DATA_W, 9, RGB width (3 bits each for R, G, B).
- ADDR_W, 16, frame RAM address width, {y,x}.
- FIFO_DEPTH, 8, PPU write FIFO entries; must be a power of 2.
- NES_H, 240, valid line count; writes with y >= NES_H are dropped.

Ports:
- pix_clk  in  1  12.5 MHz pixel clock.
- reset  in  1  synchronous, active-high.
- vga_rd_en  in  1  VGA read strobe (driver's reading output).
- vga_x  in  8  VGA pixel pointer x.
- vga_y  in  8  VGA pixel pointer y.
- vga_rdata  out  DATA_W  read data returned to the VGA driver's rgb_buf.
- vga_rvalid  out  1  vga_rdata is fresh this cycle.
- ppu_wr_valid  in  1  PPU write request.
- ppu_wr_ready  out  1  FIFO can accept a write.
- ppu_x  in  8  PPU write x.
- ppu_y  in  8  PPU write y.
- ppu_rgb  in  DATA_W  PPU write data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous, valid one cycle after mem_en with mem_we=0.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  saturating count of dropped out-of-range writes.

Behaviour:
- Reset (synchronous, active-high, clock pix_clk): state=IDLE, FIFO emptied, fifo_level=0, drop_count=0, vga_rvalid=0, vga_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation discards all queued writes. A RAM read in flight at reset is not reported: vga_rvalid=0 in the following cycle.
- FSM states: IDLE, READ, TURN, WRITE. The next state is decided combinationally each cycle and registered. The mem_* outputs are decoded combinationally from the next state.
  - Any state with vga_rd_en=1 -> READ: mem_en=1, mem_we=0, mem_addr={vga_y,vga_x}.
  - READ with vga_rd_en=0 -> TURN: exactly one idle bus cycle, mem_en=0.
  - TURN/IDLE/WRITE with vga_rd_en=0 and FIFO non-empty -> WRITE: mem_en=1, mem_we=1, address and data from the FIFO head; the head is popped in the same cycle.
  - vga_rd_en=0 and FIFO empty (and not leaving READ) -> IDLE.
- vga_rd_en pre-empts WRITE with zero delay. No write is ever issued in a cycle with vga_rd_en=1.
- Read latency is 1: a READ cycle N gives vga_rvalid=1 in cycle N+1 with vga_rdata=mem_rdata. vga_rdata is captured and held while vga_rvalid=0.
- FIFO rules:
  - Push occurs when ppu_wr_valid && ppu_wr_ready && ppu_y < NES_H.
  - ppu_wr_ready = !full. There is no bypass: a pop in the same cycle does not raise ready while full.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; a full/empty extra pointer bit distinguishes the two.
- Out-of-range write (ppu_y >= NES_H with a valid handshake): accepted (handshake completes), not pushed, drop_count += 1, saturating at 16'hFFFF.
- Write throughput: at most 1 per cycle when vga_rd_en=0. The minimum write slot after a read burst is 1 cycle late because of TURN.

Decomposition:
- fb_pkg: DATA_W, ADDR_W, NES_W=256, NES_H=240, the FSM state enum (IDLE/READ/TURN/WRITE), and the packed FIFO entry struct {addr[15:0], rgb[8:0]}.
- One sub-module, fb_wr_fifo: parameterised synchronous FIFO with valid/ready push, pop, full, empty and level.
- The arbiter FSM, read-return logic and drop counter stay in fb_port_arbiter.

Test Plan:
- Reset, idle inputs -> all outputs 0, ppu_wr_ready=1, fifo_level=0, mem_en=0 for 10 cycles.
- vga_rd_en=1, vga_y=8'd5, vga_x=8'd0..8'd255, RAM model preloaded rgb=addr[8:0] -> mem_addr=16'h0500.. each cycle with mem_we=0; vga_rvalid=1 one cycle later; vga_rdata matches the model for all 256 pixels.
- vga_rd_en=1 held, push 9 writes -> first 8 accepted, ppu_wr_ready=0 at fifo_level=8, no mem_we. vga_rd_en drops -> one TURN cycle with mem_en=0, then 8 consecutive writes in FIFO order; fifo_level returns to 0.
- FIFO holding 3 entries, vga_rd_en rises during the 2nd write -> that cycle is a read, mem_we=0, and the remaining 2 writes resume after TURN; the RAM model shows all 3 written values, none lost or duplicated.
- ppu_y=8'd240 and 8'd255 writes -> handshake completes, fifo_level unchanged, drop_count 0->2. Force drop_count=16'hFFFF and drop again -> stays 16'hFFFF.
- Reset asserted with 5 FIFO entries and a read in flight -> the next cycle has fifo_level=0, vga_rvalid=0, and no mem_we afterwards.
